product_to_seg7: RTL and testbench

Sequential binary-to-display converter that sits directly downstream of the signed multiplier. It takes the 15-bit two's-complement product, converts its magnitude to BCD with a shift-add-3 (double-dabble) engine, and emits four 7-segment digit codes plus a sign flag. The digit codes use the same segment encoding as the multiplier's operand inputs, so results can be fed back as operands.

---
 rtl/seg7_pkg.sv | 30 +++
 rtl/bcd_to_seg7.sv | 28 ++
 rtl/product_to_seg7.sv | 159 +++++++++++++++
 tb/tb_product_to_seg7.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// seg7_pkg: shared definitions for product_to_seg7.
//   - Segment codes for digits 0..9 plus blank and dash, packed as bit6=a .. bit0=g.
//   - FSM state enum for the conversion sequencer.
//   - Width localparams fixed by the multiplier product format.
package seg7_pkg;

  localparam int unsigned PROD_W = 15;
  localparam int unsigned BCD_W  = 20;

  localparam logic [6:0] SEG_0     = 7'b1111110;
  localparam logic [6:0] SEG_1     = 7'b0110000;
  localparam logic [6:0] SEG_2     = 7'b1101101;
  localparam logic [6:0] SEG_3     = 7'b1111001;
  localparam logic [6:0] SEG_4     = 7'b0110011;
  localparam logic [6:0] SEG_5     = 7'b1011011;
  localparam logic [6:0] SEG_6     = 7'b1011111;
  localparam logic [6:0] SEG_7     = 7'b1110000;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1111011;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;
  localparam logic [6:0] SEG_DASH  = 7'b0000001;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT,
    ST_ENCODE
  } state_t;

endpackage

// File: rtl/bcd_to_seg7.sv
// bcd_to_seg7: combinational BCD digit to 7-segment code.
//   i_bcd [3:0] : BCD digit 0..9 (codes 10..15 render blank)
//   o_seg [6:0] : segment code, bit6=a .. bit0=g
module bcd_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] i_bcd,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = SEG_BLANK;
    case (i_bcd)
      4'd0: o_seg = SEG_0;
      4'd1: o_seg = SEG_1;
      4'd2: o_seg = SEG_2;
      4'd3: o_seg = SEG_3;
      4'd4: o_seg = SEG_4;
      4'd5: o_seg = SEG_5;
      4'd6: o_seg = SEG_6;
      4'd7: o_seg = SEG_7;
      4'd8: o_seg = SEG_8;
      4'd9: o_seg = SEG_9;
      default: o_seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/product_to_seg7.sv
// product_to_seg7: converts a 15-bit signed product to four 7-segment digits
// plus sign/overflow flags using a sequential double-dabble engine.
//   clk, rst       : clock, asynchronous active-high reset
//   start          : conversion request, sampled only when idle
//   product [14:0] : two's-complement product, captured on accepted start
//   busy           : conversion in progress
//   done           : one-cycle pulse when the result registers update
//   sign, ovf      : result negative / magnitude above 9999
//   seg3..seg0     : thousands..units digit codes (dashes on ovf)
// Optional build macro LEADING_ZERO_BLANK_EN blanks leading zero digits in seg3..seg1.
module product_to_seg7
  import seg7_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [PROD_W-1:0]   product,
  output logic                busy,
  output logic                done,
  output logic                sign,
  output logic                ovf,
  output logic [6:0]          seg3,
  output logic [6:0]          seg2,
  output logic [6:0]          seg1,
  output logic [6:0]          seg0
);

  state_t              r_state;
  state_t              w_next;
  logic [PROD_W-1:0]   r_prod;
  logic [PROD_W-1:0]   r_mag;
  logic [BCD_W-1:0]    r_bcd;
  logic [BCD_W-1:0]    w_bcd_adj;
  logic [3:0]          r_cnt;
  logic                r_sign_q;
  logic                r_done;
  logic                r_sign;
  logic                r_ovf;
  logic [6:0]          r_seg3, r_seg2, r_seg1, r_seg0;
  logic [6:0]          w_code3, w_code2, w_code1, w_code0;
  logic [6:0]          w_seg3, w_seg2, w_seg1, w_seg0;
  logic                w_ovf;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   if (start) w_next = ST_LOAD;
      ST_LOAD:   w_next = ST_SHIFT;
      ST_SHIFT:  if (r_cnt == 4'd14) w_next = ST_ENCODE;
      ST_ENCODE: w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  // Add-3 correction on every BCD nibble that is 5 or more before the shift
  always_comb begin
    w_bcd_adj = r_bcd;
    for (int unsigned i = 0; i < BCD_W / 4; i++) begin
      if (r_bcd[4*i +: 4] >= 4'd5) w_bcd_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
    end
  end

  bcd_to_seg7 u_dig3 (.i_bcd(r_bcd[15:12]), .o_seg(w_code3));
  bcd_to_seg7 u_dig2 (.i_bcd(r_bcd[11:8]),  .o_seg(w_code2));
  bcd_to_seg7 u_dig1 (.i_bcd(r_bcd[7:4]),   .o_seg(w_code1));
  bcd_to_seg7 u_dig0 (.i_bcd(r_bcd[3:0]),   .o_seg(w_code0));

  assign w_ovf = (r_bcd[19:16] != 4'd0);

  // Dash on overflow; optional blanking of leading zeros (seg0 always shown)
  always_comb begin
    w_seg3 = w_code3;
    w_seg2 = w_code2;
    w_seg1 = w_code1;
    w_seg0 = w_code0;
    if (w_ovf) begin
      w_seg3 = SEG_DASH;
      w_seg2 = SEG_DASH;
      w_seg1 = SEG_DASH;
      w_seg0 = SEG_DASH;
    end else begin
`ifdef LEADING_ZERO_BLANK_EN
      if (r_bcd[15:12] == 4'd0) begin
        w_seg3 = SEG_BLANK;
        if (r_bcd[11:8] == 4'd0) begin
          w_seg2 = SEG_BLANK;
          if (r_bcd[7:4] == 4'd0) w_seg1 = SEG_BLANK;
        end
      end
`else
      w_seg3 = w_code3;
`endif
    end
  end

  // Datapath and result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prod   <= '0;
      r_mag    <= '0;
      r_bcd    <= '0;
      r_cnt    <= '0;
      r_sign_q <= 1'b0;
      r_done   <= 1'b0;
      r_sign   <= 1'b0;
      r_ovf    <= 1'b0;
      r_seg3   <= SEG_BLANK;
      r_seg2   <= SEG_BLANK;
      r_seg1   <= SEG_BLANK;
      r_seg0   <= SEG_BLANK;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) r_prod <= product;
        end
        ST_LOAD: begin
          r_sign_q <= r_prod[PROD_W-1];
          // -16384 negates to itself, which reads correctly as unsigned 16384
          r_mag    <= r_prod[PROD_W-1] ? (~r_prod + 1'b1) : r_prod;
          r_bcd    <= '0;
          r_cnt    <= '0;
        end
        ST_SHIFT: begin
          r_bcd <= {w_bcd_adj[BCD_W-2:0], r_mag[PROD_W-1]};
          r_mag <= {r_mag[PROD_W-2:0], 1'b0};
          r_cnt <= r_cnt + 4'd1;
        end
        ST_ENCODE: begin
          r_ovf  <= w_ovf;
          r_sign <= r_sign_q;
          r_seg3 <= w_seg3;
          r_seg2 <= w_seg2;
          r_seg1 <= w_seg1;
          r_seg0 <= w_seg0;
          r_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy = (r_state != ST_IDLE);
  assign done = r_done;
  assign sign = r_sign;
  assign ovf  = r_ovf;
  assign seg3 = r_seg3;
  assign seg2 = r_seg2;
  assign seg1 = r_seg1;
  assign seg0 = r_seg0;

endmodule

// File: tb/tb_product_to_seg7.sv
// tb_product_to_seg7: self-checking bench for product_to_seg7.
// Honours LEADING_ZERO_BLANK_EN when the same macro is defined for the bench.
module tb_product_to_seg7;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [14:0] product = '0;
  logic        busy, done, sign, ovf;
  logic [6:0]  seg3, seg2, seg1, seg0;

  product_to_seg7 dut (
    .clk(clk), .rst(rst), .start(start), .product(product),
    .busy(busy), .done(done), .sign(sign), .ovf(ovf),
    .seg3(seg3), .seg2(seg2), .seg1(seg1), .seg0(seg0)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       sgn;
    logic       ov;
    logic [6:0] s3, s2, s1, s0;
  } res_t;

  typedef struct packed {
    logic [14:0] p;
    res_t        e;
  } vec_t;

  localparam logic [6:0] SEGTAB [10] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33,
                                         7'h5B, 7'h5F, 7'h70, 7'h7F, 7'h7B};
  localparam logic [6:0] DASH = 7'h01;

  int n_pass = 0;
  int n_tot  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Reference: integer arithmetic on the signed value, digits by division
  function automatic res_t model(input logic [14:0] p);
    res_t r;
    int v, m;
    v = int'($signed(p));
    m = (v < 0) ? -v : v;
    r.sgn = (v < 0);
    r.ov  = (m > 9999);
    if (r.ov) begin
      r.s3 = DASH; r.s2 = DASH; r.s1 = DASH; r.s0 = DASH;
    end else begin
      r.s3 = SEGTAB[(m / 1000) % 10];
      r.s2 = SEGTAB[(m / 100) % 10];
      r.s1 = SEGTAB[(m / 10) % 10];
      r.s0 = SEGTAB[m % 10];
`ifdef LEADING_ZERO_BLANK_EN
      if (m < 1000) r.s3 = '0;
      if (m < 100)  r.s2 = '0;
      if (m < 10)   r.s1 = '0;
`endif
    end
    return r;
  endfunction

  // Table constants are written for the all-digits display
  function automatic res_t adjust(input res_t r);
    res_t o;
    o = r;
`ifdef LEADING_ZERO_BLANK_EN
    if (!o.ov && o.s3 == SEGTAB[0]) begin
      o.s3 = '0;
      if (o.s2 == SEGTAB[0]) begin
        o.s2 = '0;
        if (o.s1 == SEGTAB[0]) o.s1 = '0;
      end
    end
`endif
    return o;
  endfunction

  function automatic res_t outs();
    return {sign, ovf, seg3, seg2, seg1, seg0};
  endfunction

  task automatic run(input logic [14:0] p, output res_t got);
    int lat;
    @(negedge clk);
    product = p;
    start   = 1'b1;
    @(posedge clk); #1;
    start   = 1'b0;
    product = 15'($urandom);
    chk("busy_after_start", {31'd0, busy}, 32'd1);
    lat = 0;
    while (!done && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("done_latency", lat, 17);
    got = outs();
  endtask

  vec_t vecs [10];
  res_t got;
  res_t prev;
  int   lat, rises, dones;
  logic prevb;

  initial begin
    vecs[0] = '{15'h0000, '{1'b0, 1'b0, 7'h7E, 7'h7E, 7'h7E, 7'h7E}};
    vecs[1] = '{15'h59B7, '{1'b1, 1'b0, 7'h7B, 7'h7F, 7'h7E, 7'h30}};
    vecs[2] = '{15'd1234, '{1'b0, 1'b0, 7'h30, 7'h6D, 7'h79, 7'h33}};
    vecs[3] = '{15'h4000, '{1'b1, 1'b1, DASH, DASH, DASH, DASH}};
    vecs[4] = '{15'h3039, '{1'b0, 1'b1, DASH, DASH, DASH, DASH}};
    vecs[5] = '{15'd9999, '{1'b0, 1'b0, 7'h7B, 7'h7B, 7'h7B, 7'h7B}};
    vecs[6] = '{15'd10000, '{1'b0, 1'b1, DASH, DASH, DASH, DASH}};
    vecs[7] = '{15'h7FFF, '{1'b1, 1'b0, 7'h7E, 7'h7E, 7'h7E, 7'h30}};
    vecs[8] = '{15'h58F1, '{1'b1, 1'b0, 7'h7B, 7'h7B, 7'h7B, 7'h7B}};
    vecs[9] = '{15'd42,   '{1'b0, 1'b0, 7'h7E, 7'h7E, 7'h33, 7'h6D}};

    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {2'b0, busy, done, outs()}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      run(vecs[i].p, got);
      chk($sformatf("vec%0d", i), got, adjust(vecs[i].e));
    end

    for (int i = 0; i < 30; i++) begin
      logic [14:0] rp;
      rp = 15'($urandom);
      if (i % 3 == 0) rp = 15'($urandom_range(0, 120));
      run(rp, got);
      chk($sformatf("rand_%0h", rp), got, model(rp));
    end

    // start held high: single busy window, second conversion accepted on done cycle
    @(negedge clk);
    product = 15'd7;
    start   = 1'b1;
    @(posedge clk); #1;
    product = 15'd5;
    prevb = busy;
    rises = 0;
    lat = 0;
    while (!done && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (busy && !prevb) rises++;
      prevb = busy;
    end
    chk("held_first_latency", lat, 17);
    chk("single_busy_window", rises, 0);
    chk("held_first_result", outs(), model(15'd7));
    @(posedge clk); #1;
    start = 1'b0;
    chk("second_accepted", {31'd0, busy}, 32'd1);
    lat = 1;
    while (!done && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (lat == 9) chk("hold_during_conv", outs(), model(15'd7));
    end
    chk("back_to_back_gap", lat, 18);
    chk("held_second_result", outs(), model(15'd5));

    // reset during SHIFT discards the conversion
    prev = outs();
    @(negedge clk);
    product = 15'd1234;
    start   = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
    end
    chk("hold_before_reset", outs(), prev);
    rst = 1'b1;
    #1;
    chk("reset_midop", {2'b0, busy, done, outs()}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    dones = 0;
    repeat (25) begin
      @(posedge clk); #1;
      if (done) dones++;
    end
    chk("no_done_after_reset", dones, 0);
    chk("idle_after_reset", {31'd0, busy}, 32'd0);
    run(15'd99, got);
    chk("after_reset_99", got, adjust('{1'b0, 1'b0, 7'h7E, 7'h7E, 7'h7B, 7'h7B}));

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
